// File: rtl/zigzag_runlevel_4x4.sv
// Zigzag scanner for a 4x4 quantized block: emits serial (run, level) pairs
// and the CAVLC TotalCoeff / TrailingOnes statistics of the block.
module zigzag_runlevel_4x4 #(
  parameter int unsigned BIT_LENGTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH:0]   coeffs [16],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_run,
  output logic [BIT_LENGTH:0]   out_level,
  output logic                  out_last,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones,
  output logic                  block_done
);

  localparam int unsigned CW = BIT_LENGTH + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // Raster index of each zigzag position.
  function automatic logic [3:0] zz_raster(input logic [3:0] pos);
    logic [3:0] r;
    case (pos)
      4'd0:    r = 4'd0;
      4'd1:    r = 4'd1;
      4'd2:    r = 4'd4;
      4'd3:    r = 4'd8;
      4'd4:    r = 4'd5;
      4'd5:    r = 4'd2;
      4'd6:    r = 4'd3;
      4'd7:    r = 4'd6;
      4'd8:    r = 4'd9;
      4'd9:    r = 4'd12;
      4'd10:   r = 4'd13;
      4'd11:   r = 4'd10;
      4'd12:   r = 4'd7;
      4'd13:   r = 4'd11;
      4'd14:   r = 4'd14;
      default: r = 4'd15;
    endcase
    return r;
  endfunction

  function automatic logic is_unit(input logic [BIT_LENGTH:0] c);
    return (c == CW'(1)) || (c == {CW{1'b1}});
  endfunction

  state_t               state;
  logic [BIT_LENGTH:0]  blk [16];
  logic [3:0]           idx;
  logic [3:0]           run;
  logic [3:0]           last_pos;

  logic [4:0]           tc_c;
  logic [1:0]           t1_c;
  logic [3:0]           lp_c;
  logic                 t1_stop_c;
  logic [BIT_LENGTH:0]  scan_coeff_c;
  logic                 advance_c;

  // Block statistics computed from the incoming block at acceptance.
  always_comb begin
    tc_c      = '0;
    lp_c      = '0;
    t1_c      = '0;
    t1_stop_c = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (coeffs[zz_raster(4'(k))] != '0) begin
        tc_c = tc_c + 5'd1;
        lp_c = 4'(k);
      end
    end
    // Trailing ones: reverse zigzag walk, stop at |level|>1 or a count of 3.
    for (int k = 15; k >= 0; k--) begin
      if (coeffs[zz_raster(4'(k))] != '0 && !t1_stop_c) begin
        if (is_unit(coeffs[zz_raster(4'(k))]) && t1_c != 2'd3)
          t1_c = t1_c + 2'd1;
        else
          t1_stop_c = 1'b1;
      end
    end
  end

  assign scan_coeff_c = blk[zz_raster(idx)];
  assign advance_c    = !out_valid || out_ready;
  assign in_ready     = reset && enable && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      run           <= '0;
      last_pos      <= '0;
      out_valid     <= 1'b0;
      out_run       <= '0;
      out_level     <= '0;
      out_last      <= 1'b0;
      total_coeff   <= '0;
      trailing_ones <= '0;
      block_done    <= 1'b0;
      for (int i = 0; i < 16; i++) blk[i] <= '0;
    end else if (enable) begin
      block_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) blk[i] <= coeffs[i];
            total_coeff   <= tc_c;
            trailing_ones <= t1_c;
            last_pos      <= lp_c;
            idx           <= '0;
            run           <= '0;
            state         <= (tc_c == 5'd0) ? DRAIN : SCAN;
          end
        end

        SCAN: begin
          // One position per cycle, only while the output register can take a pair.
          if (advance_c) begin
            if (scan_coeff_c != '0) begin
              out_valid <= 1'b1;
              out_run   <= run;
              out_level <= scan_coeff_c;
              out_last  <= (idx == last_pos);
              run       <= '0;
            end else begin
              run <= run + 4'd1;
            end
            idx <= idx + 4'd1;
            if (idx == last_pos) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (advance_c) begin
            state      <= DONE;
            block_done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_runlevel_4x4.sv
// Directed bench for zigzag_runlevel_4x4: checks pair sequence, timing,
// block statistics, stalls, backpressure and mid-block reset.
module tb_zigzag_runlevel_4x4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] coeffs [16];
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_run;
  logic [15:0] out_level;
  logic        out_last;
  logic [4:0]  total_coeff;
  logic [1:0]  trailing_ones;
  logic        block_done;

  zigzag_runlevel_4x4 #(.BIT_LENGTH(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .coeffs(coeffs), .out_valid(out_valid),
    .out_ready(out_ready), .out_run(out_run), .out_level(out_level),
    .out_last(out_last), .total_coeff(total_coeff),
    .trailing_ones(trailing_ones), .block_done(block_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] blk [16];
  int p_run [32];
  int p_lvl [32];
  int p_last [32];
  int p_cyc [32];
  int np;
  int done_cyc;
  int rdy_cyc;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 16; i++) blk[i] = 16'd0;
  endtask

  // Accept blk at cycle 0, then watch until in_ready returns (cycle budget 60).
  task automatic run_block(input int toggle, input int stall_from, input int rst_at);
    int held;
    int h_run, h_lvl, h_last;
    np = 0; done_cyc = -1; rdy_cyc = -1; held = 0;
    h_run = 0; h_lvl = 0; h_last = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) coeffs[i] = blk[i];
    in_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
    #1 check("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk);
    for (int c = 1; c <= 60 && rdy_cyc < 0; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = (toggle != 0) ? logic'(c % 2) : 1'b1;
      enable    = !(stall_from > 0 && c >= stall_from && c < stall_from + 4);
      reset     = !(rst_at > 0 && c == rst_at);
      #1;
      if (held != 0) begin
        check("held_valid", int'(out_valid), 1);
        check("held_run", int'(out_run), h_run);
        check("held_level", int'($signed(out_level)), h_lvl);
        check("held_last", int'(out_last), h_last);
      end
      if (out_valid && out_ready && enable && np < 32) begin
        p_run[np]  = int'(out_run);
        p_lvl[np]  = int'($signed(out_level));
        p_last[np] = int'(out_last);
        p_cyc[np]  = c;
        np++;
      end
      held   = (out_valid && !(out_ready && enable)) ? 1 : 0;
      h_run  = int'(out_run);
      h_lvl  = int'($signed(out_level));
      h_last = int'(out_last);
      if (block_done) done_cyc = c;
      if (in_ready) rdy_cyc = c;
    end
    if (rdy_cyc < 0) check("timeout_in_ready", 0, 1);
    reset = 1'b1; enable = 1'b1;
  endtask

  task automatic expect_pair(input int k, input int run, input int lvl, input int last, input int cyc);
    check($sformatf("pair%0d_run", k), p_run[k], run);
    check($sformatf("pair%0d_level", k), p_lvl[k], lvl);
    check($sformatf("pair%0d_last", k), p_last[k], last);
    if (cyc >= 0) check($sformatf("pair%0d_cycle", k), p_cyc[k], cyc);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) coeffs[i] = 16'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_total_coeff", int'(total_coeff), 0);
    check("rst_trailing_ones", int'(trailing_ones), 0);
    check("rst_block_done", int'(block_done), 0);
    @(negedge clk); reset = 1'b1;
    #1 check("idle_in_ready", int'(in_ready), 1);
    enable = 1'b0;
    #1 check("stall_in_ready", int'(in_ready), 0);
    enable = 1'b1;

    // Sparse block: 5, -1, 1 up front and a lone 1 at zigzag position 11.
    clear_blk();
    blk[0] = 16'd5; blk[1] = 16'hFFFF; blk[4] = 16'd1; blk[10] = 16'd1;
    run_block(0, -1, -1);
    check("sparse_npairs", np, 4);
    expect_pair(0, 0, 5, 0, 2);
    expect_pair(1, 0, -1, 0, 3);
    expect_pair(2, 0, 1, 0, 4);
    expect_pair(3, 8, 1, 1, 13);
    check("sparse_total_coeff", int'(total_coeff), 4);
    check("sparse_trailing_ones", int'(trailing_ones), 3);
    check("sparse_done_cycle", done_cyc, 14);
    check("sparse_ready_cycle", rdy_cyc, 15);

    // All-zero block.
    clear_blk();
    run_block(0, -1, -1);
    check("zero_npairs", np, 0);
    check("zero_total_coeff", int'(total_coeff), 0);
    check("zero_trailing_ones", int'(trailing_ones), 0);
    check("zero_done_cycle", done_cyc, 2);
    check("zero_ready_cycle", rdy_cyc, 3);

    // Dense block of 2s under alternating backpressure.
    for (int i = 0; i < 16; i++) blk[i] = 16'd2;
    run_block(1, -1, -1);
    check("dense_npairs", np, 16);
    for (int k = 0; k < 16; k++) expect_pair(k, 0, 2, (k == 15) ? 1 : 0, -1);
    check("dense_last_cycle", p_cyc[15], 33);
    check("dense_done_cycle", done_cyc, 34);
    check("dense_total_coeff", int'(total_coeff), 16);
    check("dense_trailing_ones", int'(trailing_ones), 0);

    // Single -1 at the final zigzag position.
    clear_blk();
    blk[15] = 16'hFFFF;
    run_block(0, -1, -1);
    check("single_npairs", np, 1);
    expect_pair(0, 15, -1, 1, 17);
    check("single_total_coeff", int'(total_coeff), 1);
    check("single_trailing_ones", int'(trailing_ones), 1);
    check("single_done_cycle", done_cyc, 18);

    // Zigzag levels 3,-1,1,1,-1: trailing ones capped at 3.
    clear_blk();
    blk[0] = 16'd3; blk[1] = 16'hFFFF; blk[4] = 16'd1; blk[8] = 16'd1; blk[5] = 16'hFFFF;
    run_block(0, -1, -1);
    check("cap_npairs", np, 5);
    expect_pair(4, 0, -1, 1, 6);
    check("cap_total_coeff", int'(total_coeff), 5);
    check("cap_trailing_ones", int'(trailing_ones), 3);

    // Sparse block again with enable low for cycles 3..6.
    clear_blk();
    blk[0] = 16'd5; blk[1] = 16'hFFFF; blk[4] = 16'd1; blk[10] = 16'd1;
    run_block(0, 3, -1);
    check("stall_npairs", np, 4);
    expect_pair(0, 0, 5, 0, 2);
    expect_pair(1, 0, -1, 0, 7);
    expect_pair(2, 0, 1, 0, 8);
    expect_pair(3, 8, 1, 1, 17);
    check("stall_done_cycle", done_cyc, 18);
    check("stall_ready_cycle", rdy_cyc, 19);

    // Same block, reset pulsed during cycle 5 of the scan.
    run_block(0, -1, 5);
    check("rst_mid_npairs", np, 3);
    check("rst_mid_ready_cycle", rdy_cyc, 6);
    check("rst_mid_done", done_cyc, -1);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_total_coeff", int'(total_coeff), 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid || block_done) check("rst_mid_quiet", 1, 0);
    end
    check("rst_mid_idle_ready", int'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
